// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_W      = 4;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_convert_seq_if.sv
// Start/ready/done handshake and data bus between the capture logic and the BCD converter.
interface bcd_convert_seq_if #(
    parameter int WIDTH  = bcd_pkg::DEF_WIDTH,
    parameter int DIGITS = bcd_pkg::DEF_DIGITS
);

    logic                        start;
    logic [WIDTH-1:0]            bin;
    logic                        ready;
    logic                        done;
    logic [bcd_pkg::BCD_W*DIGITS-1:0] bcd;

    modport master (output start, output bin, input ready, input done, input bcd);
    modport slave  (input start, input bin, output ready, output done, output bcd);

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to any BCD digit of 5 or more before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_W'(5)) ? i_digit + BCD_W'(3) : i_digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential shift-and-add-3 converter: one input bit per clock, result held until the next conversion.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic clk,
    input  logic reset,
    bcd_convert_seq_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_TOTAL = BCD_W * DIGITS;

    state_e                 r_state;
    logic [WIDTH-1:0]       r_shift;
    logic [BCD_TOTAL-1:0]   r_digits;
    logic [BCD_TOTAL-1:0]   r_bcd;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_done;

    logic [BCD_TOTAL-1:0]   w_corr;
    logic [BCD_TOTAL-1:0]   w_next_digits;
    logic [WIDTH-1:0]       w_next_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_digits[g*BCD_W +: BCD_W]),
            .o_digit (w_corr[g*BCD_W +: BCD_W])
        );
    end

    // Corrected digits and the binary shift register move left together as one long word.
    assign w_next_digits = {w_corr[BCD_TOTAL-2:0], r_shift[WIDTH-1]};
    assign w_next_shift  = {r_shift[WIDTH-2:0], 1'b0};

    // NOTE: non-blocking assignments so every register samples pre-edge values, matching flop behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_digits <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift  <= bus.bin;
                        r_digits <= '0;
                        r_cnt    <= CNT_W'(WIDTH - 1);
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_digits <= w_next_digits;
                    r_shift  <= w_next_shift;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_bcd   <= w_next_digits;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.done  = r_done;
    assign bus.bcd   = r_bcd;

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the 4x4 array multiplier. It takes the 8-bit product and produces packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. The BCD digits feed the existing seven_seg decoders so that the product is shown in decimal rather than hex. A start/ready/done handshake lets the upstream capture logic launch a conversion whenever the operands change.

Parameters:
WIDTH, 8, binary input width (multiplier product width).
DIGITS, 3, number of BCD output digits; must satisfy 10**DIGITS > 2**WIDTH-1.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a conversion of bin; sampled only when ready=1.
bin  input  WIDTH  unsigned binary value (multiplier out[7:0]).
ready  output  1  high only in IDLE; the block accepts start this cycle.
done  output  1  one-cycle pulse; bcd has just been updated.
bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; held between conversions.

Behaviour:
- One clock, clk; reset is synchronous and active-high. After a reset edge: state IDLE, ready=1, done=0, bcd=0, all internal scratch cleared.
- Reset mid-conversion aborts the conversion. bcd returns to 0 and no done pulse is produced.
- States:
  - IDLE: ready=1. If start=1 at a clock edge, latch bin into the shift register, clear the digit scratch, load the bit counter with WIDTH-1, and go to SHIFT.
  - SHIFT: ready=0. Each edge performs one iteration:
    - Every scratch digit >= 5 gets +3 (4-bit, no carry out).
    - Then {digits, shift register} is shifted left by 1.
    - The counter decrements.
    - On the edge where the counter is 0 (the WIDTH-th iteration), the post-iteration digits are written into the bcd register, done is set, and the state goes to DONE.
  - DONE: ready=0, done=1 for exactly this cycle. Next edge goes to IDLE with done=0.
- Latency: start sampled at edge k; bcd valid and done=1 in the cycle after edge k+WIDTH (8 cycles for the defaults). Earliest next start is sampled at edge k+WIDTH+2.
- start while ready=0 is ignored, with no queueing. bin is don't-care except at the accepting edge; later changes do not affect the running conversion.
- bcd changes only on the completing edge or on reset; it is stable otherwise, including during SHIFT.
- Arithmetic: the scratch digits are exactly 4*DIGITS bits. Given the DIGITS constraint, no digit overflows past 9 after the final shift. Any bin value 0..2**WIDTH-1 is legal.
- Counter width is $clog2(WIDTH). No combinational path from start or bin to any output.

Decomposition:
- Shared package bcd_pkg:
  - state enum typedef (IDLE, SHIFT, DONE), 2 bits.
  - BCD digit width constant (4).
  - localparam default WIDTH/DIGITS values used by the top level.
- One natural sub-module, bcd_add3: a combinational 4-bit digit corrector (out = in>=5 ? in+3 : in), instantiated DIGITS times via generate.
- The top level wires the multiplier's out[7:0] to bin and bcd[3:0]/[7:4]/[11:8] to three seven_seg instances.

Test Plan:
- Reset, then hold start=0 for 5 cycles -> ready=1, done=0, bcd=12'h000 throughout.
- bin=8'd225 (15*15), pulse start -> ready=0 next cycle; done=1 exactly one cycle, 8 cycles after the start edge; bcd=12'h225. Then ready=1 again.
- Sweep bin=0, 9, 10, 99, 100, 255 with back-to-back starts issued on the first ready cycle -> bcd=12'h000, 009, 010, 099, 100, 255 respectively. Each done pulse is one cycle wide.
- bin=8'd144 accepted; during SHIFT pulse start with bin=8'd7 and also change bin -> the second start is ignored, the result is 12'h144, and only one done pulse occurs.
- bin=8'd200 accepted; assert reset 4 cycles into SHIFT -> bcd=0, done never pulses, ready=1 after the reset edge. A fresh start with bin=8'd56 then gives 12'h056.
- Previous result 12'h225 held, no start for 20 cycles -> bcd remains 12'h225 and done stays 0.
